// File: rtl/mips16_pkg.sv
// mips16_pkg: instruction-memory geometry and loader state encoding shared by the boot loader.
package mips16_pkg;
  localparam int IMEM_DEPTH = 1024;
  localparam int IMEM_AW = 10;
  localparam int WORD_W = 16;
  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_LEN   = 3'd1,
    LD_DATA  = 3'd2,
    LD_CSUM  = 3'd3,
    LD_RUN   = 3'd4,
    LD_ERROR = 3'd5
  } ld_state_e;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: pairs stream bytes (high byte first) into 16-bit words.
module word_assembler
  import mips16_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o
);
  logic       phase_q;
  logic [7:0] hi_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
    end else if (clear_i) begin
      phase_q <= 1'b0;
    end else if (byte_valid_i) begin
      phase_q <= ~phase_q;
      if (!phase_q) hi_q <= byte_i;
    end
  end
  assign word_valid_o = byte_valid_i & phase_q;
  assign word_o       = {hi_q, byte_i};
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, checksummed byte stream and writes it into
// instruction memory, holding the CPU stalled until the image is verified.
module imem_loader
  import mips16_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               in_valid_i,
  input  logic [7:0]         in_data_i,
  output logic               in_ready_o,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [WORD_W-1:0]  imem_wdata_o,
  output logic               cpu_run_o,
  output logic               busy_o,
  output logic               error_o
);
  localparam logic [IMEM_AW:0]  CNT_ONE = 1;
  localparam logic [WORD_W-1:0] MAX_LEN = WORD_W'(IMEM_DEPTH);
  ld_state_e          state_q;
  logic [IMEM_AW:0]   count_q, len_q, count_d;
  logic [WORD_W-1:0]  sum_q, wdata_q, word;
  logic [IMEM_AW-1:0] addr_q;
  logic               ready_q, we_q, run_q, busy_q, err_q;
  logic               fire, clear, word_valid;
  assign fire    = in_valid_i & ready_q;
  assign clear   = start_i & ~busy_q;
  assign count_d = count_q + CNT_ONE;
  word_assembler u_asm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear),
    .byte_valid_i(fire),
    .byte_i      (in_data_i),
    .word_valid_o(word_valid),
    .word_o      (word)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LD_IDLE;
      count_q <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        LD_IDLE, LD_RUN, LD_ERROR: if (start_i) begin
          state_q <= LD_LEN;
          count_q <= '0;
          sum_q   <= '0;
          ready_q <= 1'b1;
          busy_q  <= 1'b1;
          run_q   <= 1'b0;
          err_q   <= 1'b0;
        end
        LD_LEN: if (word_valid) begin
          len_q <= word[IMEM_AW:0];
          if (word == '0) begin
            state_q <= LD_CSUM;
          end else if (word > MAX_LEN) begin
            state_q <= LD_ERROR;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            state_q <= LD_DATA;
          end
        end
        LD_DATA: if (word_valid) begin
          we_q    <= 1'b1;
          addr_q  <= count_q[IMEM_AW-1:0];
          wdata_q <= word;
          sum_q   <= sum_q + word;
          count_q <= count_d;
          if (count_d == len_q) state_q <= LD_CSUM;
        end
        LD_CSUM: if (word_valid) begin
          state_q <= (word == sum_q) ? LD_RUN : LD_ERROR;
          run_q   <= (word == sum_q);
          err_q   <= (word != sum_q);
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= LD_IDLE;
      endcase
    end
  end
  assign in_ready_o   = ready_q;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign cpu_run_o    = run_q;
  assign busy_o       = busy_q;
  assign error_o      = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed loads checked every cycle against a byte-stream model.
module tb_imem_loader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, we, cpu_run, busy, error;
  logic [9:0]  addr;
  logic [15:0] wdata;
  int checks = 0, errors = 0;
  logic [9:0]  la[$];
  logic [15:0] ld[$];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .imem_we_o(we), .imem_addr_o(addr), .imem_wdata_o(wdata),
    .cpu_run_o(cpu_run), .busy_o(busy), .error_o(error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 loading, 2 run, 3 error; the accepted bytes of the current load are kept
  // and interpreted by their position in the stream.
  int          m_mode = 0, m_n = 0;
  logic [7:0]  m_b[$];
  logic        e_ready = 0, e_we = 0, e_run = 0, e_busy = 0, e_err = 0;
  logic [9:0]  e_addr = 0;
  logic [15:0] e_wdata = 0;

  always @(posedge clk or negedge rst_n) begin : model
    int k;
    logic [15:0] w, s;
    if (!rst_n) begin
      m_mode = 0; m_n = 0; m_b.delete();
      e_ready = 0; e_we = 0; e_run = 0; e_busy = 0; e_err = 0; e_addr = 0; e_wdata = 0;
    end else begin
      e_we = 0;
      if (m_mode != 1 && start) begin
        m_mode = 1; m_b.delete();
        e_ready = 1; e_busy = 1; e_run = 0; e_err = 0;
      end else if (m_mode == 1 && in_valid) begin
        m_b.push_back(in_data);
        if (m_b.size() % 2 == 0) begin
          k = m_b.size() / 2 - 1;
          w = {m_b[2*k], m_b[2*k+1]};
          if (k == 0) begin
            m_n = int'(w);
            if (m_n > 1024) begin m_mode = 3; e_err = 1; e_ready = 0; e_busy = 0; end
          end else if (k <= m_n) begin
            e_we = 1; e_addr = 10'(k - 1); e_wdata = w;
          end else begin
            s = 0;
            for (int i = 1; i <= m_n; i++) s = s + {m_b[2*i], m_b[2*i+1]};
            m_mode = (s == w) ? 2 : 3;
            e_run = (s == w); e_err = (s != w); e_ready = 0; e_busy = 0;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("in_ready", in_ready, e_ready);
    chk("imem_we", we, e_we);
    chk("imem_addr", addr, e_addr);
    chk("imem_wdata", wdata, e_wdata);
    chk("cpu_run", cpu_run, e_run);
    chk("busy", busy, e_busy);
    chk("error", error, e_err);
    if (we) begin la.push_back(addr); ld.push_back(wdata); end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    start = 1; @(negedge clk); start = 0;
  endtask

  task automatic clr_log;
    la.delete(); ld.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    in_valid = 1; in_data = b;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    if (t == 20) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte %0h at %0t", b, $time);
    end
    @(negedge clk);
    start = 0;
    if (gap > 0) begin in_valid = 0; in_data = 8'($urandom); cyc(gap); end
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int gm, input int st_at);
    int gap;
    for (int i = 0; i < s.size(); i++) begin
      if (i == st_at) start = 1;
      gap = (gm == 0) ? 0 : (gm == 1) ? 1 : (($urandom % 3 == 0) ? $urandom_range(1, 3) : 0);
      send_byte(s[i], gap);
    end
    in_valid = 0;
  endtask

  task automatic make_stream(input int n, input bit good, output logic [7:0] s[$]);
    logic [15:0] sum = 0, w;
    s.delete();
    s.push_back(8'(n >> 8)); s.push_back(8'(n));
    if (n <= 1024) begin
      for (int i = 0; i < n; i++) begin
        w = 16'($urandom); sum = sum + w;
        s.push_back(w[15:8]); s.push_back(w[7:0]);
      end
      if (!good) sum = sum ^ 16'(1 << $urandom_range(0, 15));
      s.push_back(sum[15:8]); s.push_back(sum[7:0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] nom[$], bad[$], s[$];
    int n;
    nom = '{8'h00, 8'h02, 8'h51, 8'h00, 8'h52, 8'h02, 8'hA3, 8'h02};
    cyc(3); rst_n = 1;
    in_valid = 1; in_data = 8'hFF; cyc(5); in_valid = 0;
    chk("idle_ready", in_ready, 0);
    chk("idle_we", we, 0);
    chk("idle_addr", addr, 0);
    chk("idle_wdata", wdata, 0);
    chk("idle_busy", busy, 0);
    chk("idle_writes", la.size(), 0);

    clr_log(); pulse_start();
    chk("nom_busy", busy, 1);
    send_stream(nom, 0, -1);
    chk("nom_run", cpu_run, 1);
    chk("nom_model_run", e_run, 1);
    chk("nom_nwr", la.size(), 2);
    chk("nom_a0", la[0], 0);  chk("nom_d0", ld[0], 16'h5100);
    chk("nom_a1", la[1], 1);  chk("nom_d1", ld[1], 16'h5202);

    bad = nom; bad[7] = 8'h03;
    clr_log(); pulse_start(); send_stream(bad, 0, -1);
    chk("bad_err", error, 1); chk("bad_model_err", e_err, 1);
    chk("bad_run", cpu_run, 0); chk("bad_nwr", la.size(), 2);

    s = '{8'h00, 8'h00, 8'h00, 8'h00};
    clr_log(); pulse_start(); send_stream(s, 0, -1);
    chk("len0_run", cpu_run, 1); chk("len0_nwr", la.size(), 0);

    s = '{8'h04, 8'h01};
    clr_log(); pulse_start(); send_stream(s, 0, -1);
    chk("len1025_err", error, 1); chk("len1025_busy", busy, 0);
    chk("len1025_nwr", la.size(), 0);

    make_stream(1024, 1, s);
    clr_log(); pulse_start(); send_stream(s, 0, -1);
    chk("len1024_run", cpu_run, 1); chk("len1024_nwr", la.size(), 1024);
    chk("len1024_last_a", la[1023], 1023);
    chk("len1024_last_d", ld[1023], {s[2048], s[2049]});

    clr_log(); pulse_start(); send_stream(nom, 1, 4);
    chk("gap_run", cpu_run, 1); chk("gap_nwr", la.size(), 2);
    chk("gap_d0", ld[0], 16'h5100); chk("gap_d1", ld[1], 16'h5202);

    s = '{8'h00, 8'h02, 8'h51, 8'h00};
    clr_log(); pulse_start(); send_stream(s, 0, -1);
    cyc(1); rst_n = 0; cyc(1); rst_n = 1;
    chk("rst_run", cpu_run, 0); chk("rst_busy", busy, 0); chk("rst_ready", in_ready, 0);
    chk("rst_nwr", la.size(), 1);
    clr_log(); pulse_start(); send_stream(nom, 0, -1);
    chk("reload_run", cpu_run, 1); chk("reload_nwr", la.size(), 2);

    repeat (30) begin
      n = ($urandom % 5 == 0) ? 1025 + $urandom_range(0, 3000) : $urandom_range(0, 12);
      make_stream(n, $urandom % 4 != 0, s);
      in_valid = 1'($urandom); in_data = 8'($urandom); cyc($urandom_range(0, 3));
      pulse_start();
      send_stream(s, 2, ($urandom % 3 == 0) ? $urandom_range(0, s.size() - 1) : -1);
      cyc($urandom_range(1, 3));
    end
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the 16-bit single-cycle CPU. It receives a length-prefixed, checksummed byte stream and assembles it into 16-bit instruction words. It writes those words into the CPU instruction memory starting at word address 0 and holds the CPU stalled until a verified image is in place. It is the write side of the instruction memory, which the CPU only ever reads.

## Interface
Parameters:
- IMEM_AW, 10, instruction-memory word-address width (1024 words)
- WORD_W, 16, instruction word width

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a load from IDLE, RUN or ERROR
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_ready  out  1  byte-stream ready; a byte transfers when in_valid && in_ready
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  IMEM_AW  word address of the current write
- imem_wdata  out  WORD_W  word being written
- cpu_run  out  1  CPU may fetch; 0 holds the CPU PC at 0
- busy  out  1  load in progress (LEN, DATA or CSUM)
- error  out  1  image rejected

## Operation
- Stream format: length word N, then N instruction words, then checksum word. Every word is sent high byte first.
- States: IDLE, LEN, DATA, CSUM, RUN, ERROR.
- IDLE: in_ready=0. On start, go to LEN and clear the address counter, the checksum accumulator and the byte phase.
- LEN: in_ready=1. When the low byte arrives, latch N.
  - N=0: go to CSUM.
  - N>1024: go to ERROR.
  - Otherwise: go to DATA.
- DATA: in_ready=1. On each completed word:
  - write it to imem_addr = count;
  - add it to the sum, modulo 2^16;
  - increment count (11-bit counter).
  - When count reaches N, go to CSUM.
- CSUM: in_ready=1. When the checksum word completes, go to RUN if it equals the sum; otherwise go to ERROR.
- RUN: cpu_run=1, in_ready=0. On start, drop cpu_run and go to LEN.
- ERROR: error=1, in_ready=0. On start, clear error and go to LEN.
- start during LEN, DATA or CSUM is ignored.
- Bytes presented while in_ready=0 are not consumed.
- The block never backpressures while loading: in_ready is a pure function of state.
- Reset mid-load returns the block to IDLE. Memory already written is not cleared, and cpu_run stays 0 until a full verified load completes.

## Timing
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_run=0, busy=0, error=0. Internal count, sum and byte phase are all 0.
- All outputs are registered.
- in_ready rises in the cycle after start is sampled.
- imem_we pulses high for exactly one cycle, in the cycle after the low-byte handshake. imem_addr and imem_wdata are valid in the same cycle.
- imem_addr and imem_wdata hold their values after the pulse until the next write.
- Peak throughput: 1 byte per cycle, so one write every 2 cycles.
- cpu_run or error asserts in the cycle after the checksum low-byte handshake.
- busy is 1 exactly while the state is LEN, DATA or CSUM.
- The address counter must not wrap: N=1024 writes addresses 0..1023 and then stops.

## Structure
- Shared package mips16_pkg holds:
  - IMEM_DEPTH=1024, IMEM_AW=10, WORD_W=16;
  - the loader state encoding (3-bit constants: IDLE=0, LEN=1, DATA=2, CSUM=3, RUN=4, ERROR=5).
- One sub-module: word_assembler.
  - Holds the byte phase and high-byte register.
  - Emits word_valid plus the 16-bit word when the low byte completes a word.
  - Has a clear input driven on start.
- The top level holds the FSM, count, sum and output registers.

## Test plan
- Reset then idle: reset_n low, then high, with no start and in_valid=1 -> all outputs 0 and no writes.
- Nominal load: start, then bytes 00 02 51 00 52 02 A3 02 ->
  - writes (0, 0x5100) and (1, 0x5202);
  - each imem_we pulse is one cycle;
  - cpu_run=1 in the cycle after the final byte.
- Bad checksum: same stream with the last byte 03 -> error=1, cpu_run=0, exactly 2 writes.
- Edge lengths:
  - length 0x0000 followed by checksum 00 00 -> RUN with no writes;
  - length 0x0401 -> ERROR after the second byte with no writes;
  - length 1024 -> last write at address 1023.
- Gapped stream and ignored start: in_valid toggled every other cycle, with start pulsed mid-DATA -> same writes as the nominal load, and start is ignored.
- Reset mid-DATA, then reload: reset_n pulsed after the first write, followed by start and the nominal stream -> cpu_run=0 after reset; the rerun loads correctly and reaches RUN.
